// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if -- requester/UART bundle for uart_tx_arbiter.
//   i_req / i_word / i_nbytes   : per-requester word, length (bytes-1) and pending flag
//   i_uart_data_sent            : UART TX idle flag (high = idle)
//   o_uart_data / o_uart_send_data : byte + send request toward the UART
//   o_grant / o_done            : one-hot pulses per requester
//   o_busy                      : arbiter is mid-word
// Modports: master = requesters/UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int DATA_BITS = 8,
    parameter int NBITS     = 32,
    parameter int N_REQ     = 2
);
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*NBITS-1:0] i_word;
    logic [N_REQ*2-1:0]     i_nbytes;
    logic                   i_uart_data_sent;
    logic [DATA_BITS-1:0]   o_uart_data;
    logic                   o_uart_send_data;
    logic [N_REQ-1:0]       o_grant;
    logic [N_REQ-1:0]       o_done;
    logic                   o_busy;

    modport master (
        output i_req, i_word, i_nbytes, i_uart_data_sent,
        input  o_uart_data, o_uart_send_data, o_grant, o_done, o_busy
    );

    modport slave (
        input  i_req, i_word, i_nbytes, i_uart_data_sent,
        output o_uart_data, o_uart_send_data, o_grant, o_done, o_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one UART transmitter among N_REQ word requesters.
// A granted requester's word is latched and sent MSB-first as 1..4 bytes
// over the UART send/sent handshake; o_done pulses after the last byte.
// Ports:
//   i_clk  : clock, all logic on posedge
//   i_rst  : synchronous active-high reset
//   bus    : uart_tx_arbiter_if.slave (requests, words, UART handshake, pulses)
// Configuration macro: UART_TX_ARB_RR_EN
//   defined   -> round-robin arbitration starting after the last winner
//   undefined -> fixed priority, lowest index wins (no rr pointer)
module uart_tx_arbiter #(
    parameter int DATA_BITS = 8,
    parameter int NBITS     = 32,
    parameter int N_REQ     = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t               state;
    logic [NBITS-1:0]     shift;
    logic [1:0]           byte_cnt;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     winner;
    logic [DATA_BITS-1:0] uart_data;
    logic                 send;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic                 busy;
    logic                 any_req;

    assign any_req = |bus.i_req;

`ifdef UART_TX_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    int               idx;

    // Search starts one past the last winner and wraps, so the requester
    // just served is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!found && bus.i_req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end
`else
    // Descending scan: the last hit, i.e. the lowest set index, wins.
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.i_req[i]) winner = IDX_W'(i);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            shift     <= '0;
            byte_cnt  <= '0;
            owner     <= '0;
            uart_data <= '0;
            send      <= 1'b0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
`ifdef UART_TX_ARB_RR_EN
            rr_ptr    <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        shift     <= bus.i_word[winner*NBITS +: NBITS];
                        byte_cnt  <= bus.i_nbytes[winner*2 +: 2];
                        owner     <= winner;
                        // First byte is taken straight from the input word so
                        // it is valid in the very first SEND cycle.
                        uart_data <= bus.i_word[winner*NBITS + (NBITS - DATA_BITS) +: DATA_BITS];
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        grant     <= ONE << winner;
                        state     <= SEND;
`ifdef UART_TX_ARB_RR_EN
                        rr_ptr    <= winner;
`endif
                    end
                end
                SEND: begin
                    // The UART acknowledges by dropping its idle flag.
                    if (!bus.i_uart_data_sent) begin
                        send  <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.i_uart_data_sent) begin
                        if (byte_cnt == 2'd0) begin
                            done  <= ONE << owner;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            byte_cnt  <= byte_cnt - 2'd1;
                            shift     <= shift << DATA_BITS;
                            // Next byte is the one just below the current MSB byte.
                            uart_data <= shift[NBITS-DATA_BITS-1 -: DATA_BITS];
                            send      <= 1'b1;
                            state     <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_uart_data      = uart_data;
    assign bus.o_uart_send_data = send;
    assign bus.o_grant          = grant;
    assign bus.o_done           = done;
    assign bus.o_busy           = busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- directed bench for uart_tx_arbiter (2 requesters).
// Inputs change and outputs are sampled 1 time unit after each posedge.
module tb_uart_tx_arbiter;
    localparam int DATA_BITS = 8;
    localparam int NBITS     = 32;
    localparam int N_REQ     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   rises = 0;
    int   rises_snap;
    logic send_d = 1'b0;
    logic [31:0] word0, word1;
    logic [1:0]  nb0, nb1;

    uart_tx_arbiter_if #(.DATA_BITS(DATA_BITS), .NBITS(NBITS), .N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(.DATA_BITS(DATA_BITS), .NBITS(NBITS), .N_REQ(N_REQ)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.i_word   = {word1, word0};
    assign bus.i_nbytes = {nb1, nb0};

    // Counts rising edges of the send request.
    always @(negedge clk) begin
        send_d <= bus.o_uart_send_data;
        if (bus.o_uart_send_data && !send_d) rises <= rises + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One byte over the UART: expects SEND with byte 'exp', then holds the
    // idle flag low for 'low' cycles before releasing it.
    task automatic xfer_byte(input string tag, input logic [7:0] exp, input int low);
        check({tag, "_send"}, 64'(bus.o_uart_send_data), 64'd1);
        check({tag, "_data"}, 64'(bus.o_uart_data), 64'(exp));
        bus.i_uart_data_sent = 1'b0;
        tick();
        check({tag, "_send_drop"}, 64'(bus.o_uart_send_data), 64'd0);
        check({tag, "_data_hold"}, 64'(bus.o_uart_data), 64'(exp));
        for (int i = 1; i < low; i++) begin
            tick();
            if (bus.o_uart_send_data !== 1'b0)
                check({tag, "_send_low"}, 64'(bus.o_uart_send_data), 64'd0);
        end
        bus.i_uart_data_sent = 1'b1;
        tick();
    endtask

    logic [1:0] exp_gnt [4];
    logic [7:0] exp_byte[4];

    initial begin
        bus.i_req = '0;
        bus.i_uart_data_sent = 1'b1;
        word0 = '0; word1 = '0; nb0 = '0; nb1 = '0;
`ifdef UART_TX_ARB_RR_EN
        exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_byte = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
`else
        exp_gnt  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_byte = '{8'hA1, 8'hA1, 8'hA1, 8'hA1};
`endif

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_busy",  64'(bus.o_busy), 64'd0);
        check("rst_send",  64'(bus.o_uart_send_data), 64'd0);
        check("rst_data",  64'(bus.o_uart_data), 64'd0);
        check("rst_grant", 64'(bus.o_grant), 64'd0);
        check("rst_done",  64'(bus.o_done), 64'd0);

        // 4-byte word 0xDEADBEEF from requester 0
        word0 = 32'hDEADBEEF; nb0 = 2'd3; bus.i_req = 2'b01;
        tick();
        check("w1_grant", 64'(bus.o_grant), 64'h1);
        check("w1_busy",  64'(bus.o_busy), 64'd1);
        bus.i_req = 2'b00;
        xfer_byte("w1_b0", 8'hDE, 1);
        check("w1_grant_pulse", 64'(bus.o_grant), 64'h0);
        xfer_byte("w1_b1", 8'hAD, 1);
        xfer_byte("w1_b2", 8'hBE, 1);
        check("w1_no_early_done", 64'(bus.o_done), 64'h0);
        xfer_byte("w1_b3", 8'hEF, 1);
        check("w1_done", 64'(bus.o_done), 64'h1);
        check("w1_idle", 64'(bus.o_busy), 64'd0);
        tick();
        check("w1_done_pulse", 64'(bus.o_done), 64'h0);
        check("w1_busy_after", 64'(bus.o_busy), 64'd0);

        // 1-byte word 0x12345678: only 0x12 goes out
        word0 = 32'h12345678; nb0 = 2'd0; bus.i_req = 2'b01;
        tick();
        check("w2_grant", 64'(bus.o_grant), 64'h1);
        bus.i_req = 2'b00;
        xfer_byte("w2_b0", 8'h12, 1);
        check("w2_done", 64'(bus.o_done), 64'h1);
        tick(); tick();
        check("w2_no_more_send", 64'(bus.o_uart_send_data), 64'd0);
        check("w2_data_not_34",  64'(bus.o_uart_data), 64'h12);

        // Both requesters held high for 4 words, after a reset
        rst = 1'b1; tick(); rst = 1'b0;
        word0 = 32'hA1000000; word1 = 32'hB2000000; nb0 = 2'd0; nb1 = 2'd0;
        bus.i_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("arb_grant%0d", k), 64'(bus.o_grant), 64'(exp_gnt[k]));
            xfer_byte($sformatf("arb_b%0d", k), exp_byte[k], 1);
            check($sformatf("arb_done%0d", k), 64'(bus.o_done), 64'(exp_gnt[k]));
            if (k == 3) bus.i_req = 2'b00;
        end
        tick();
        check("arb_idle", 64'(bus.o_busy), 64'd0);

        // Reset in the 2nd byte of a 4-byte word, then requester 1
        rst = 1'b1; tick(); rst = 1'b0;
        word0 = 32'hDEADBEEF; nb0 = 2'd3; bus.i_req = 2'b01;
        tick();
        check("mr_grant", 64'(bus.o_grant), 64'h1);
        bus.i_req = 2'b00;
        xfer_byte("mr_b0", 8'hDE, 1);
        check("mr_b1_send", 64'(bus.o_uart_send_data), 64'd1);
        check("mr_b1_data", 64'(bus.o_uart_data), 64'hAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_send_drop", 64'(bus.o_uart_send_data), 64'd0);
        check("mr_busy", 64'(bus.o_busy), 64'd0);
        check("mr_no_done", 64'(bus.o_done), 64'h0);
        tick();
        check("mr_no_done2", 64'(bus.o_done), 64'h0);
        word1 = 32'hCAFEF00D; nb1 = 2'd1; bus.i_req = 2'b10;
        tick();
        check("mr_grant1", 64'(bus.o_grant), 64'h2);
        bus.i_req = 2'b00;
        xfer_byte("mr_r1_b0", 8'hCA, 1);
        xfer_byte("mr_r1_b1", 8'hFE, 1);
        check("mr_r1_done", 64'(bus.o_done), 64'h2);

        // Slow UART: 100 low cycles per byte, 3 bytes
        tick();
        rises_snap = rises;
        word1 = 32'h0BADC0DE; nb1 = 2'd2; bus.i_req = 2'b10;
        tick();
        check("slow_grant", 64'(bus.o_grant), 64'h2);
        bus.i_req = 2'b00;
        xfer_byte("slow_b0", 8'h0B, 100);
        xfer_byte("slow_b1", 8'hAD, 100);
        xfer_byte("slow_b2", 8'hC0, 100);
        check("slow_done", 64'(bus.o_done), 64'h2);
        tick(); tick();
        check("slow_pulses", 64'(rises - rises_snap), 64'd3);
        check("slow_send_idle", 64'(bus.o_uart_send_data), 64'd0);

        // UART never acknowledges: SEND persists, no done, no second grant
        word0 = 32'h55AA55AA; nb0 = 2'd0; bus.i_req = 2'b01;
        tick();
        check("stk_grant", 64'(bus.o_grant), 64'h1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.o_uart_send_data !== 1'b1 || bus.o_grant !== 2'b00 ||
                bus.o_done !== 2'b00 || bus.o_busy !== 1'b1) begin
                check("stk_send",  64'(bus.o_uart_send_data), 64'd1);
                check("stk_grant2", 64'(bus.o_grant), 64'h0);
                check("stk_done",  64'(bus.o_done), 64'h0);
                check("stk_busy",  64'(bus.o_busy), 64'd1);
            end
        end
        check("stk_send_end", 64'(bus.o_uart_send_data), 64'd1);
        check("stk_data_end", 64'(bus.o_uart_data), 64'h55);
        check("stk_done_end", 64'(bus.o_done), 64'h0);
        bus.i_req = 2'b00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
